inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit.sv | 132 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Small synchronous FIFO with flush; head entry is readable combinationally.
// Latency: a word pushed at edge N is at the head after edge N when the FIFO was empty.
// Backpressure: the caller must not push when full unless popping in the same cycle.
module fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage array; contents need no reset because empty entries are never exposed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

endmodule

// Instruction fetch: drives the memory word address and queues {pc, inst} toward decode.
// Latency: an instruction fetched at edge N is offered (out_valid=1) right after edge N.
// Backpressure: fetch stalls while the queue is full and decode is not taking the head.
module inst_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] out_inst_addr,
  input  logic [31:0] in_inst,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        out_valid,
  input  logic        in_ready,
  input  logic        in_redirect,
  input  logic [63:0] in_redirect_pc
);

  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

  logic [63:0] fetch_pc;
  logic        fifo_empty;
  logic        fifo_full;
  logic [95:0] head;
  logic        pop;
  logic        push;

  // Decode takes the head whenever it is valid and ready; a redirect in the
  // same cycle still completes that handshake, the flush just discards the rest.
  assign pop  = out_valid & in_ready & ~rst;

  // Fetch every cycle there is room, counting the slot freed by this cycle's pop.
  assign push = ~rst & ~in_redirect & (~fifo_full | pop);

  // Memory is word addressed; the low two PC bits are always zero.
  assign out_inst_addr = {2'b00, fetch_pc[63:2]};

  // Fetch PC: reset wins over redirect, redirect wins over sequential advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC & PC_ALIGN_MASK;
    end else if (in_redirect) begin
      fetch_pc <= in_redirect_pc & PC_ALIGN_MASK;
    end else if (push) begin
      fetch_pc <= fetch_pc + 64'd4;
    end
  end

  fifo #(
    .W     (96),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (in_redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({fetch_pc, in_inst}),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Empty queue presents zeros rather than whatever stale entry the pointer sits on.
  assign out_valid = ~fifo_empty;
  assign out_pc    = out_valid ? head[95:32] : 64'h0;
  assign out_inst  = out_valid ? head[31:0]  : 32'h0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: RESET_PC = 0
  logic        rst0, rdy0, redir0;
  logic [63:0] redir_pc0, addr0, pc0;
  logic [31:0] inst_in0, inst0;
  logic        v0;

  // dut1: RESET_PC near the top of the address space
  logic        rst1, rdy1;
  logic [63:0] addr1, pc1;
  logic [31:0] inst_in1, inst1;
  logic        v1;

  localparam logic [63:0] HI_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  int tests = 0;
  int fails = 0;
  logic [95:0] q0[$];
  logic [95:0] q1[$];

  function automatic logic [31:0] mem_word(input logic [63:0] waddr);
    return 32'h1000_0000 + 32'(waddr);
  endfunction

  assign inst_in0 = mem_word(addr0);
  assign inst_in1 = mem_word(addr1);

  inst_fetch_unit #(.RESET_PC(64'h0), .DEPTH(2)) dut0 (
    .clk(clk), .rst(rst0), .out_inst_addr(addr0), .in_inst(inst_in0),
    .out_inst(inst0), .out_pc(pc0), .out_valid(v0), .in_ready(rdy0),
    .in_redirect(redir0), .in_redirect_pc(redir_pc0)
  );

  inst_fetch_unit #(.RESET_PC(HI_PC), .DEPTH(2)) dut1 (
    .clk(clk), .rst(rst1), .out_inst_addr(addr1), .in_inst(inst_in1),
    .out_inst(inst1), .out_pc(pc1), .out_valid(v1), .in_ready(rdy1),
    .in_redirect(1'b0), .in_redirect_pc(64'h0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect0(input logic [63:0] pc);
    q0.push_back({pc, mem_word(pc >> 2)});
  endtask

  task automatic expect1(input logic [63:0] pc);
    q1.push_back({pc, mem_word(pc >> 2)});
  endtask

  // Called at a negedge with inputs settled: scores the handshake that the
  // coming posedge will complete, then advances to the next negedge.
  task automatic tick();
    logic [95:0] e;
    if (v0 && rdy0) begin
      tests++;
      assert (q0.size() > 0) else begin
        fails++;
        $error("FAIL dut0_sb: observed handshake pc %h, expected none queued", pc0);
      end
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("dut0_pc", pc0, e[95:32]);
        chk("dut0_inst", {32'h0, inst0}, {32'h0, e[31:0]});
      end
    end
    if (v1 && rdy1) begin
      tests++;
      assert (q1.size() > 0) else begin
        fails++;
        $error("FAIL dut1_sb: observed handshake pc %h, expected none queued", pc1);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("dut1_pc", pc1, e[95:32]);
        chk("dut1_inst", {32'h0, inst1}, {32'h0, e[31:0]});
      end
    end
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst0 = 1'b1; rdy0 = 1'b1; redir0 = 1'b0; redir_pc0 = 64'h0;
    rst1 = 1'b1; rdy1 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_valid", {63'h0, v0}, 64'h0);
    chk("rst_pc", pc0, 64'h0);
    chk("rst_inst", {32'h0, inst0}, 64'h0);
    chk("rst_addr", addr0, 64'h0);
    chk("rst_addr_hi", addr1, HI_PC >> 2);
    chk("rst_valid_hi", {63'h0, v1}, 64'h0);

    // Streaming with in_ready held: one instruction per cycle
    rst0 = 1'b0;
    for (int k = 0; k < 6; k++) expect0(64'(4 * k));
    tick();
    chk("first_valid", {63'h0, v0}, 64'h1);
    ticks(6);
    chk("stream_drained", 64'(q0.size()), 64'h0);

    // Backpressure after reset: fill to two entries, then drain without gaps
    rst0 = 1'b1; rdy0 = 1'b0;
    tick();
    rst0 = 1'b0;
    ticks(5);
    chk("stall_addr", addr0, 64'h2);
    chk("stall_valid", {63'h0, v0}, 64'h1);
    chk("stall_pc", pc0, 64'h0);
    chk("stall_inst", {32'h0, inst0}, 64'h1000_0000);
    expect0(64'h0); expect0(64'h4); expect0(64'h8); expect0(64'hC);
    rdy0 = 1'b1;
    ticks(4);
    chk("bp_drained", 64'(q0.size()), 64'h0);

    // Redirect to 0x40 while holding pc 4 and 8 (with a same-cycle pop of pc 4)
    rst0 = 1'b1; rdy0 = 1'b0;
    tick();
    rst0 = 1'b0;
    ticks(3);
    expect0(64'h0); expect0(64'h4);
    rdy0 = 1'b1;
    tick();
    chk("pre_redir_head", pc0, 64'h4);
    chk("pre_redir_addr", addr0, 64'h3);
    redir0 = 1'b1; redir_pc0 = 64'h40;
    tick();
    chk("redir_valid", {63'h0, v0}, 64'h0);
    chk("redir_pc_zero", pc0, 64'h0);
    chk("redir_inst_zero", {32'h0, inst0}, 64'h0);
    chk("redir_addr", addr0, 64'h10);
    redir0 = 1'b0;
    expect0(64'h40); expect0(64'h44);
    tick();
    chk("redir_revalid", {63'h0, v0}, 64'h1);
    ticks(2);

    // Misaligned redirect target is forced to word alignment
    rdy0 = 1'b0; redir0 = 1'b1; redir_pc0 = 64'h43;
    tick();
    chk("mis_addr", addr0, 64'h10);
    chk("mis_valid", {63'h0, v0}, 64'h0);
    redir0 = 1'b0;
    tick();
    chk("mis_head_pc", pc0, 64'h40);
    chk("mis_head_inst", {32'h0, inst0}, 64'h1000_0010);
    expect0(64'h40); expect0(64'h44);
    rdy0 = 1'b1;
    ticks(2);

    // Reset and redirect together: reset wins
    rdy0 = 1'b0;
    ticks(2);
    rst0 = 1'b1; redir0 = 1'b1; redir_pc0 = 64'h1234;
    tick();
    chk("rr_valid", {63'h0, v0}, 64'h0);
    chk("rr_addr", addr0, 64'h0);
    chk("rr_pc", pc0, 64'h0);
    rst0 = 1'b0; redir0 = 1'b0; rdy0 = 1'b1;
    expect0(64'h0);
    ticks(2);
    rdy0 = 1'b0;
    chk("q0_drained", 64'(q0.size()), 64'h0);

    // PC wrap modulo 2^64
    rst1 = 1'b0; rdy1 = 1'b1;
    expect1(HI_PC); expect1(HI_PC + 64'd4); expect1(64'h0); expect1(64'h4);
    ticks(5);
    rdy1 = 1'b0;
    chk("q1_drained", 64'(q1.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
